array_mp: RTL and testbench

ARRAY_MP -- requirements
Module: array_mp

---
 rtl/array_pkg.sv | 18 +
 rtl/array_mp_if.sv | 33 +++
 rtl/array_wr_arb.sv | 36 +++
 rtl/array_mp.sv | 107 ++++++++++
 tb/tb_array_mp.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_pkg.sv
// Shared types and constants for the dual-port word array (array_mp).
package array_pkg;

  localparam int unsigned NDef  = 16;
  localparam int unsigned AwDef = 4;
  localparam int unsigned DwDef = 32;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // Widened compare keeps the range check meaningful when N is not a power of two.
  function automatic logic addr_ok(input int unsigned addr, input int unsigned n);
    return addr < n;
  endfunction

endpackage

// File: rtl/array_mp_if.sv
// Request/response bundle for the two access ports of array_mp.
interface array_mp_if
  import array_pkg::*;
#(
  parameter int unsigned AW = AwDef,
  parameter int unsigned DW = DwDef
);
  logic          out0_valid;
  logic          out0_we;
  logic [AW-1:0] out0_addr;
  logic [DW-1:0] out0_di;
  logic [DW-1:0] out0_do;
  logic          out0_ready;

  logic          out1_valid;
  logic          out1_we;
  logic [AW-1:0] out1_addr;
  logic [DW-1:0] out1_di;
  logic [DW-1:0] out1_do;
  logic          out1_ready;

  modport master (
    output out0_valid, out0_we, out0_addr, out0_di,
    output out1_valid, out1_we, out1_addr, out1_di,
    input  out0_do, out0_ready, out1_do, out1_ready
  );

  modport slave (
    input  out0_valid, out0_we, out0_addr, out0_di,
    input  out1_valid, out1_we, out1_addr, out1_di,
    output out0_do, out0_ready, out1_do, out1_ready
  );
endinterface

// File: rtl/array_wr_arb.sv
// Two-requester round-robin write arbiter; rr flips only on contested cycles.
module array_wr_arb
  import array_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic rr_q, rr_d;

  always_comb begin
    gnt0 = en & req0;
    gnt1 = en & req1;
    rr_d = rr_q;
    if (en && req0 && req1) begin
      // Holder of rr wins, then hands priority to the loser.
      gnt0 = (rr_q == Port0);
      gnt1 = (rr_q == Port1);
      rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_q <= Port0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/array_mp.sv
// Dual-port word array: async reads, one arbitrated write per cycle.
// ARRAY_MP_INIT_EN enables a post-reset sweep writing data[i] = i.
module array_mp
  import array_pkg::*;
#(
  parameter int unsigned N  = NDef,
  parameter int unsigned AW = AwDef,
  parameter int unsigned DW = DwDef
) (
  input  logic      clk,
  input  logic      nrst,
  array_mp_if.slave bus,
  output logic      busy
);

  logic [DW-1:0] mem_q [N];

  logic          run;
  logic          en;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic          gnt0, gnt1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

`ifdef ARRAY_MP_INIT_EN
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(N - 1)) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  assign run       = (state_q == StRun);
  assign busy      = (state_q == StInit);
  assign init_we   = (state_q == StInit);
  assign init_addr = cnt_q;
`else
  assign run       = 1'b1;
  assign busy      = 1'b0;
  assign init_we   = 1'b0;
  assign init_addr = '0;
`endif

  // nrst gating keeps both ready low for the whole time reset is held.
  assign en = run & nrst;

  array_wr_arb u_arb (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .req0 (bus.out0_valid & bus.out0_we),
    .req1 (bus.out1_valid & bus.out1_we),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign bus.out0_ready = en & bus.out0_valid & (~bus.out0_we | gnt0);
  assign bus.out1_ready = en & bus.out1_valid & (~bus.out1_we | gnt1);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = init_addr;
    wr_data = DW'(init_addr);
    if (init_we) begin
      wr_en = 1'b1;
    end else if (gnt0) begin
      wr_en   = addr_ok(32'(bus.out0_addr), N);
      wr_addr = bus.out0_addr;
      wr_data = bus.out0_di;
    end else if (gnt1) begin
      wr_en   = addr_ok(32'(bus.out1_addr), N);
      wr_addr = bus.out1_addr;
      wr_data = bus.out1_di;
    end
  end

  // Storage is deliberately not reset; an edge seen with nrst low drops its write.
  always_ff @(posedge clk) begin
    if (wr_en && nrst) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus.out0_do = addr_ok(32'(bus.out0_addr), N) ? mem_q[bus.out0_addr] : '0;
  assign bus.out1_do = addr_ok(32'(bus.out1_addr), N) ? mem_q[bus.out1_addr] : '0;

endmodule

// File: tb/tb_array_mp.sv
// Scoreboard bench for array_mp; works with or without ARRAY_MP_INIT_EN.
module tb_array_mp;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

`ifdef ARRAY_MP_INIT_EN
  localparam logic ExpBusy = 1'b1;
`else
  localparam logic ExpBusy = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  array_mp_if #(.AW(AW), .DW(DW)) bus ();

  array_mp #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic [DW-1:0] do0;
    logic [DW-1:0] do1;
    logic          rdy0;
    logic          rdy1;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_mem [N];
  logic          m_rr = 1'b0;
  logic          m_run = 1'b1;
  logic          pend_we = 1'b0;
  logic          pend_flip = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  int            checks = 0;
  int            errors = 0;

  // Drives one request cycle and pushes the model's expected response.
  task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    exp_t e;
    logic both;
    bus.out0_valid = v0; bus.out0_we = w0; bus.out0_addr = a0; bus.out0_di = d0;
    bus.out1_valid = v1; bus.out1_we = w1; bus.out1_addr = a1; bus.out1_di = d1;
    both   = v0 && w0 && v1 && w1;
    e.do0  = m_mem[a0];
    e.do1  = m_mem[a1];
    e.rdy0 = m_run && v0 && (!w0 || !both || m_rr == 1'b0);
    e.rdy1 = m_run && v1 && (!w1 || !both || m_rr == 1'b1);
    pend_we   = 1'b0;
    pend_flip = m_run && both;
    if (v0 && w0 && e.rdy0) begin
      pend_we = 1'b1; pend_addr = a0; pend_data = d0;
    end else if (v1 && w1 && e.rdy1) begin
      pend_we = 1'b1; pend_addr = a1; pend_data = d1;
    end
    sb_q.push_back(e);
  endtask

  task automatic commit();
    @(posedge clk);
    if (pend_we) m_mem[pend_addr] = pend_data;
    if (pend_flip) m_rr = ~m_rr;
    pend_we   = 1'b0;
    pend_flip = 1'b0;
    #1;
  endtask

  task automatic idle();
    bus.out0_valid = 1'b0; bus.out0_we = 1'b0; bus.out0_addr = '0; bus.out0_di = '0;
    bus.out1_valid = 1'b0; bus.out1_we = 1'b0; bus.out1_addr = '0; bus.out1_di = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.out0_valid = 1'b1; bus.out0_we = 1'b0; bus.out0_addr = '0; bus.out0_di = '0;
    bus.out1_valid = 1'b1; bus.out1_we = 1'b1; bus.out1_addr = '0; bus.out1_di = '1;
    nrst = 1'b0;
    #2;
    checks++;
    if ({busy, bus.out0_ready, bus.out1_ready} !== {ExpBusy, 2'b00}) begin
      errors++;
      $display("FAIL reset_hold: busy/rdy=%b%b%b want %b00", busy, bus.out0_ready,
               bus.out1_ready, ExpBusy);
    end
    @(posedge clk); #1;
    nrst = 1'b1; m_rr = 1'b0; m_run = 1'b1;
`ifdef ARRAY_MP_INIT_EN
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, bus.out0_ready, bus.out1_ready} !== 3'b100) begin
        errors++;
        $display("FAIL sweep cycle %0d: busy/rdy=%b%b%b want 100", i, busy, bus.out0_ready,
                 bus.out1_ready);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) m_mem[i] = DW'(i);
`else
    // No sweep: load data[i] = i through port 0, reading back each word a cycle later.
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b1, AW'(i), DW'(i), (i > 0), 1'b0, AW'(i - 1), '0);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({busy, bus.out0_ready, bus.out1_ready} !== {1'b0, e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL preload %0d: busy/rdy=%b%b%b want 0%b%b", i, busy, bus.out0_ready,
                 bus.out1_ready, e.rdy0, e.rdy1);
      end
      if (i > 0) begin
        checks++;
        if (bus.out1_do !== e.do1) begin
          errors++;
          $display("FAIL preload_rd %0d: do1=%h want %h", i, bus.out1_do, e.do1);
        end
      end
      commit();
    end
`endif
    drive(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd15, '0);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({busy, bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready} !==
        {1'b0, e.do0, e.do1, e.rdy0, e.rdy1}) begin
      errors++;
      $display("FAIL post_reset_rd: busy=%b do0=%h do1=%h want busy=0 do0=%h do1=%h", busy,
               bus.out0_do, bus.out1_do, e.do0, e.do1);
    end
    commit();
    idle();
  endtask

  task automatic test_rd_during_wr();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      if (s == 0) drive(1'b1, 1'b1, 4'd3, 32'hDEAD, 1'b1, 1'b0, 4'd3, '0);
      else        drive(1'b0, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd3, '0);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready} !==
          {e.do0, e.do1, e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL rd_during_wr step %0d: do0=%h do1=%h rdy=%b%b want %h %h %b%b", s,
                 bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready, e.do0, e.do1,
                 e.rdy0, e.rdy1);
      end
      commit();
    end
    idle();
  endtask

  task automatic test_contested();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      if (s < 2) drive(1'b1, 1'b1, 4'd7, 32'h11, 1'b1, 1'b1, 4'd7, 32'h22);
      else       drive(1'b1, 1'b0, 4'd7, '0, 1'b1, 1'b0, 4'd7, '0);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready} !==
          {e.do0, e.do1, e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL contested step %0d: do0=%h do1=%h rdy=%b%b want %h %h %b%b", s,
                 bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready, e.do0, e.do1,
                 e.rdy0, e.rdy1);
      end
      commit();
    end
    idle();
  endtask

  // Lone writers never move rr; each contested cycle afterwards checks who holds it.
  task automatic test_single_writer();
    exp_t e;
    for (int s = 0; s < 10; s++) begin
      if (s < 4)
        drive(1'b1, 1'b1, AW'(10 + s), DW'(32'hA0 + s), 1'b1, 1'b0, AW'(9 + s), '0);
      else if (s == 4 || s == 9)
        drive(1'b1, 1'b1, 4'd1, DW'(32'hC0 + s), 1'b1, 1'b1, 4'd1, DW'(32'hD0 + s));
      else
        drive(1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b1, AW'(s), DW'(32'hB0 + s));
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready} !==
          {e.do0, e.do1, e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL single_writer step %0d: do0=%h do1=%h rdy=%b%b want %h %h %b%b", s,
                 bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready, e.do0, e.do1,
                 e.rdy0, e.rdy1);
      end
      commit();
    end
    idle();
  endtask

  task automatic test_random();
    exp_t e;
    for (int s = 0; s < 200; s++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            AW'($urandom_range(0, 7)), DW'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
            AW'($urandom_range(0, 7)), DW'($urandom));
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready} !==
          {e.do0, e.do1, e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL random step %0d: do0=%h do1=%h rdy=%b%b want %h %h %b%b", s,
                 bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready, e.do0, e.do1,
                 e.rdy0, e.rdy1);
      end
      commit();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Make sure rr points at port 1 so its reset to port 0 is visible.
    if (m_rr == 1'b0) begin
      drive(1'b1, 1'b1, 4'd2, 32'h100, 1'b1, 1'b1, 4'd2, 32'h200);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({bus.out0_ready, bus.out1_ready} !== {e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL pre_reset_rr: rdy=%b%b want %b%b", bus.out0_ready, bus.out1_ready,
                 e.rdy0, e.rdy1);
      end
      commit();
    end
    drive(1'b1, 1'b1, 4'd9, 32'hBEEF, 1'b0, 1'b0, 4'd0, '0);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if ({bus.out0_do, bus.out0_ready} !== {e.do0, e.rdy0}) begin
      errors++;
      $display("FAIL mid_wr: do0=%h rdy0=%b want %h %b", bus.out0_do, bus.out0_ready, e.do0,
               e.rdy0);
    end
    commit();
    // In-flight write caught by reset must be dropped.
    bus.out0_valid = 1'b1; bus.out0_we = 1'b1; bus.out0_addr = 4'd9; bus.out0_di = 32'hCAFE;
    bus.out1_valid = 1'b1; bus.out1_we = 1'b0; bus.out1_addr = 4'd9; bus.out1_di = '0;
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, bus.out0_ready, bus.out1_ready} !== {ExpBusy, 2'b00}) begin
      errors++;
      $display("FAIL mid_run_reset: busy/rdy=%b%b%b want %b00", busy, bus.out0_ready,
               bus.out1_ready, ExpBusy);
    end
    @(posedge clk); #1;
    nrst = 1'b1; m_rr = 1'b0; pend_we = 1'b0; pend_flip = 1'b0;
`ifdef ARRAY_MP_INIT_EN
    repeat (5) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, bus.out0_ready, bus.out1_ready} !== 3'b100) begin
      errors++;
      $display("FAIL mid_init_reset: busy/rdy=%b%b%b want 100", busy, bus.out0_ready,
               bus.out1_ready);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, bus.out0_ready, bus.out1_ready} !== 3'b100) begin
        errors++;
        $display("FAIL resweep cycle %0d: busy/rdy=%b%b%b want 100", i, busy, bus.out0_ready,
                 bus.out1_ready);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) m_mem[i] = DW'(i);
`endif
    for (int s = 0; s < 3; s++) begin
      if (s == 1) drive(1'b1, 1'b1, 4'd2, 32'hA, 1'b1, 1'b1, 4'd2, 32'hB);
      else        drive(1'b1, 1'b0, 4'd9, '0, 1'b1, 1'b0, 4'd2, '0);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if ({busy, bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready} !==
          {1'b0, e.do0, e.do1, e.rdy0, e.rdy1}) begin
        errors++;
        $display("FAIL after_reset step %0d: busy=%b do0=%h do1=%h rdy=%b%b want %h %h %b%b",
                 s, busy, bus.out0_do, bus.out1_do, bus.out0_ready, bus.out1_ready, e.do0,
                 e.do1, e.rdy0, e.rdy1);
      end
      commit();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_rd_during_wr();
    test_contested();
    test_single_writer();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
